// File: rtl/instruction_decoder_sequencer_pkg.sv
// Shared opcode encodings, destination codes and control-bit indices of the 4-bit CPU.
package cpu4_pkg;

  localparam int unsigned WORD_W = 8;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned SRC_W  = 4;
  localparam int unsigned EN_W   = 9;
  localparam int unsigned NOP_W  = 4;

  // Opcode classes: (ir & MASK) == VAL
  localparam logic [WORD_W-1:0] OP_LOAD_MASK = 8'h80;
  localparam logic [WORD_W-1:0] OP_LOAD_VAL  = 8'h00;
  localparam logic [WORD_W-1:0] OP_MOVE_MASK = 8'hC0;
  localparam logic [WORD_W-1:0] OP_MOVE_VAL  = 8'h80;
  localparam logic [WORD_W-1:0] OP_ALU_MASK  = 8'hE0;
  localparam logic [WORD_W-1:0] OP_ALU_VAL   = 8'hC0;
  localparam logic [WORD_W-1:0] OP_JMP_MASK  = 8'hF0;
  localparam logic [WORD_W-1:0] OP_JMP_VAL   = 8'hE0;
  localparam logic [WORD_W-1:0] OP_JNZ_MASK  = 8'hF0;
  localparam logic [WORD_W-1:0] OP_JNZ_VAL   = 8'hF0;

  // ALU encodings that are no-ops with a dedicated flag
  localparam logic [WORD_W-1:0] NOP_C8 = 8'hC8;
  localparam logic [WORD_W-1:0] NOP_CF = 8'hCF;
  localparam logic [WORD_W-1:0] NOP_D8 = 8'hD8;
  localparam logic [WORD_W-1:0] NOP_DF = 8'hDF;

  typedef enum logic [2:0] {
    DST_X0 = 3'd0, DST_X1 = 3'd1, DST_Y0 = 3'd2, DST_Y1 = 3'd3,
    DST_O  = 3'd4, DST_M  = 3'd5, DST_I  = 3'd6, DST_DM = 3'd7
  } dst_e;

  // source_sel codes
  localparam logic [SRC_W-1:0] SRC_X0    = 4'd0;
  localparam logic [SRC_W-1:0] SRC_R     = 4'd4;
  localparam logic [SRC_W-1:0] SRC_DM    = 4'd7;
  localparam logic [SRC_W-1:0] SRC_PM    = 4'd8;
  localparam logic [SRC_W-1:0] SRC_IPINS = 4'd9;

  // reg_en bit indices
  localparam int unsigned EN_R  = 4;
  localparam int unsigned EN_M  = 5;
  localparam int unsigned EN_I  = 6;
  localparam int unsigned EN_DM = 7;
  localparam int unsigned EN_O  = 8;

  // One-hot write enable for a destination code; o_reg lives at the top bit.
  function automatic logic [EN_W-1:0] dst_en(input dst_e d);
    logic [EN_W-1:0] en;
    en = '0;
    if (d == DST_O) en[EN_O] = 1'b1;
    else            en[d]    = 1'b1;
    return en;
  endfunction

endpackage

// File: rtl/instruction_decoder_sequencer_if.sv
// Program-memory fetch and computational-unit control bundle.
interface instruction_decoder_sequencer_if #(
  parameter int unsigned PC_W = 8
);
  import cpu4_pkg::*;

  logic [WORD_W-1:0] pm_data;
  logic              r_eq_0;
  logic [PC_W-1:0]   pm_addr;
  logic [WORD_W-1:0] ir;
  logic [NIB_W-1:0]  nibble_ir;
  logic [SRC_W-1:0]  source_sel;
  logic [EN_W-1:0]   reg_en;
  logic              i_sel;
  logic              x_sel;
  logic              y_sel;
  logic              NOPC8;
  logic              NOPCF;
  logic              NOPD8;
  logic              NOPDF;
  logic              bubble;

  modport master (
    input  pm_data, r_eq_0,
    output pm_addr, ir, nibble_ir, source_sel, reg_en, i_sel, x_sel, y_sel,
           NOPC8, NOPCF, NOPD8, NOPDF, bubble
  );

  modport slave (
    output pm_data, r_eq_0,
    input  pm_addr, ir, nibble_ir, source_sel, reg_en, i_sel, x_sel, y_sel,
           NOPC8, NOPCF, NOPD8, NOPDF, bubble
  );
endinterface

// File: rtl/instruction_decoder_sequencer_pc_sequencer.sv
// Program counter with increment/wrap, jump redirect and one-slot bubble flag.
module pc_sequencer #(
  parameter int unsigned      PC_W     = 8,
  parameter logic [PC_W-1:0]  RESET_PC = '0
) (
  input  logic            clk,
  input  logic            sync_reset,
  input  logic            jump_i,
  input  logic            taken_i,
  input  logic [PC_W-1:0] target_i,
  output logic [PC_W-1:0] pc_o,
  output logic            bubble_o
);

  logic [PC_W-1:0] pc_q, pc_d;
  logic            bubble_q, bubble_d;

  // Next pc: sequential unless a live jump redirects; any jump squashes the next slot.
  always_comb begin
    pc_d     = pc_q + PC_W'(1);
    bubble_d = 1'b0;
    if (jump_i) begin
      bubble_d = 1'b1;
      if (taken_i) pc_d = target_i;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      pc_q     <= RESET_PC;
      bubble_q <= 1'b1;
    end else begin
      pc_q     <= pc_d;
      bubble_q <= bubble_d;
    end
  end

  assign pc_o     = pc_q;
  assign bubble_o = bubble_q;

endmodule

// File: rtl/instruction_decoder_sequencer.sv
// Instruction fetch, IR and combinational decode into computational-unit controls.
module instruction_decoder_sequencer
  import cpu4_pkg::*;
#(
  parameter int unsigned     PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic clk,
  input  logic sync_reset,
  instruction_decoder_sequencer_if.master bus
);

  logic [WORD_W-1:0] ir_q, ir_d;
  logic              bubble;
  logic              is_jmp, is_jnz, jump_c, taken_c;
  logic [SRC_W-1:0]  src_sel_c;
  logic [EN_W-1:0]   reg_en_c;
  logic              i_sel_c;
  logic [NOP_W-1:0]  nop_c;
  dst_e              dst;
  logic [2:0]        src;
  logic              wr, dm_acc;

  assign is_jmp  = (ir_q & OP_JMP_MASK) == OP_JMP_VAL;
  assign is_jnz  = (ir_q & OP_JNZ_MASK) == OP_JNZ_VAL;
  assign jump_c  = (is_jmp | is_jnz) & ~bubble;
  assign taken_c = is_jmp | (is_jnz & ~bus.r_eq_0);
  assign ir_d    = bus.pm_data;

  pc_sequencer #(.PC_W(PC_W), .RESET_PC(RESET_PC)) u_pc (
    .clk        (clk),
    .sync_reset (sync_reset),
    .jump_i     (jump_c),
    .taken_i    (taken_c),
    .target_i   (bus.pm_data[PC_W-1:0]),
    .pc_o       (bus.pm_addr),
    .bubble_o   (bubble)
  );

  // Instruction register: every cycle fetches the word at pm_addr.
  always_ff @(posedge clk) begin
    if (sync_reset) ir_q <= '0;
    else            ir_q <= ir_d;
  end

  // Decode IR into bus source, write enables, i update and NOP flags.
  always_comb begin
    src_sel_c = SRC_X0;
    reg_en_c  = '0;
    i_sel_c   = 1'b0;
    nop_c     = '0;
    dst       = DST_X0;
    src       = 3'd0;
    wr        = 1'b0;
    dm_acc    = 1'b0;
    if (!bubble) begin
      if ((ir_q & OP_LOAD_MASK) == OP_LOAD_VAL) begin
        dst       = dst_e'(ir_q[6:4]);
        src_sel_c = SRC_PM;
        wr        = 1'b1;
        dm_acc    = (dst == DST_DM);
      end else if ((ir_q & OP_MOVE_MASK) == OP_MOVE_VAL) begin
        dst       = dst_e'(ir_q[5:3]);
        src       = ir_q[2:0];
        wr        = 1'b1;
        src_sel_c = (src == dst) ? SRC_IPINS : SRC_W'(src);
        dm_acc    = (dst == DST_DM) || ((src == 3'd7) && (src != dst));
      end else if ((ir_q & OP_ALU_MASK) == OP_ALU_VAL) begin
        src_sel_c = SRC_X0;
        case (ir_q)
          NOP_C8:  nop_c[0] = 1'b1;
          NOP_CF:  nop_c[1] = 1'b1;
          NOP_D8:  nop_c[2] = 1'b1;
          NOP_DF:  nop_c[3] = 1'b1;
          default: reg_en_c[EN_R] = 1'b1;
        endcase
      end
    end
    if (wr) begin
      reg_en_c = dst_en(dst);
      // A bus write to i takes precedence over the dm post-increment.
      if (dst == DST_I) begin
        reg_en_c[EN_I] = 1'b1;
        i_sel_c        = 1'b0;
      end else if (dm_acc) begin
        reg_en_c[EN_I] = 1'b1;
        i_sel_c        = 1'b1;
      end
    end
  end

  assign bus.ir         = ir_q;
  assign bus.nibble_ir  = ir_q[3:0];
  assign bus.x_sel      = ir_q[4];
  assign bus.y_sel      = ir_q[3];
  assign bus.source_sel = src_sel_c;
  assign bus.reg_en     = reg_en_c;
  assign bus.i_sel      = i_sel_c;
  assign bus.NOPC8      = nop_c[0];
  assign bus.NOPCF      = nop_c[1];
  assign bus.NOPD8      = nop_c[2];
  assign bus.NOPDF      = nop_c[3];
  assign bus.bubble     = bubble;

endmodule

// File: tb/tb_instruction_decoder_sequencer.sv
// Directed bench: decode vector table plus jump, wrap and reset sequences.
module tb_instruction_decoder_sequencer;

  logic       clk;
  logic       sync_reset;
  logic       r_eq_0;
  logic [7:0] pm [256];
  int         total;
  int         bad;

  instruction_decoder_sequencer_if bus();

  assign bus.pm_data = pm[bus.pm_addr];
  assign bus.r_eq_0  = r_eq_0;

  instruction_decoder_sequencer dut (
    .clk        (clk),
    .sync_reset (sync_reset),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] word;
    logic [8:0] en;
    logic [3:0] src;
    logic       isel;
    logic       xs;
    logic       ys;
    logic [3:0] nop;   // {DF, D8, CF, C8}
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < 256; i++) pm[i] = v;
  endtask

  task automatic do_reset();
    sync_reset = 1'b1;
    step();
    step();
    sync_reset = 1'b0;
  endtask

  // Step until pm_addr reaches a; the next step then executes pm[a].
  task automatic wait_addr(input logic [7:0] a);
    int n;
    n = 0;
    while (bus.pm_addr !== a && n < 600) begin
      step();
      n++;
    end
    check("wait_addr", 32'(bus.pm_addr), 32'(a));
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    sync_reset = 1'b1;
    r_eq_0     = 1'b0;

    //         word   en      src   isel xs ys nop
    vecs[0]  = '{8'h35, 9'h008, 4'd8, 0, 1, 0, 4'b0000};
    vecs[1]  = '{8'h88, 9'h002, 4'd0, 0, 0, 1, 4'b0000};
    vecs[2]  = '{8'h9B, 9'h008, 4'd9, 0, 1, 1, 4'b0000};
    vecs[3]  = '{8'h87, 9'h041, 4'd7, 1, 0, 0, 4'b0000};
    vecs[4]  = '{8'hB7, 9'h040, 4'd7, 0, 1, 0, 4'b0000};
    vecs[5]  = '{8'hD2, 9'h010, 4'd0, 0, 1, 0, 4'b0000};
    vecs[6]  = '{8'hCF, 9'h000, 4'd0, 0, 0, 1, 4'b0010};
    vecs[7]  = '{8'hC8, 9'h000, 4'd0, 0, 0, 1, 4'b0001};
    vecs[8]  = '{8'hD8, 9'h000, 4'd0, 0, 1, 1, 4'b0100};
    vecs[9]  = '{8'hDF, 9'h000, 4'd0, 0, 1, 1, 4'b1000};
    vecs[10] = '{8'hBF, 9'h0C0, 4'd9, 1, 1, 1, 4'b0000};
    vecs[11] = '{8'h4A, 9'h100, 4'd8, 0, 0, 1, 4'b0000};
    vecs[12] = '{8'h7C, 9'h0C0, 4'd8, 1, 1, 1, 4'b0000};
    vecs[13] = '{8'h6A, 9'h040, 4'd8, 0, 0, 1, 4'b0000};
    vecs[14] = '{8'hA6, 9'h100, 4'd6, 0, 0, 0, 4'b0000};
    vecs[15] = '{8'hCC, 9'h010, 4'd0, 0, 0, 1, 4'b0000};

    // Reset state and decode table
    fill(8'h00);
    for (int i = 0; i < 16; i++) pm[i] = vecs[i].word;
    sync_reset = 1'b1;
    step();
    step();
    check("rst_addr",   32'(bus.pm_addr), 32'h00);
    check("rst_bubble", 32'(bus.bubble),  32'h1);
    check("rst_en",     32'(bus.reg_en),  32'h000);
    check("rst_ir",     32'(bus.ir),      32'h00);
    check("rst_src",    32'(bus.source_sel), 32'h0);
    sync_reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step();
      check("v_ir",     32'(bus.ir),         32'(vecs[i].word));
      check("v_bubble", 32'(bus.bubble),     32'h0);
      check("v_en",     32'(bus.reg_en),     32'(vecs[i].en));
      check("v_src",    32'(bus.source_sel), 32'(vecs[i].src));
      check("v_isel",   32'(bus.i_sel),      32'(vecs[i].isel));
      check("v_xsel",   32'(bus.x_sel),      32'(vecs[i].xs));
      check("v_ysel",   32'(bus.y_sel),      32'(vecs[i].ys));
      check("v_nop",    32'({bus.NOPDF, bus.NOPD8, bus.NOPCF, bus.NOPC8}), 32'(vecs[i].nop));
      check("v_nib",    32'(bus.nibble_ir),  32'(vecs[i].word[3:0]));
    end

    // JMP at 0x10 to 0x40
    fill(8'h00);
    pm[8'h10] = 8'hE0;
    pm[8'h11] = 8'h40;
    pm[8'h40] = 8'h35;
    do_reset();
    wait_addr(8'h10);
    step();
    check("jmp_ir",      32'(bus.ir),      32'hE0);
    check("jmp_en",      32'(bus.reg_en),  32'h000);
    step();
    check("jmp_addr",    32'(bus.pm_addr), 32'h40);
    check("jmp_bubble",  32'(bus.bubble),  32'h1);
    check("jmp_b_en",    32'(bus.reg_en),  32'h000);
    check("jmp_b_src",   32'(bus.source_sel), 32'h0);
    step();
    check("jmp_tgt_ir",  32'(bus.ir),      32'h35);
    check("jmp_tgt_en",  32'(bus.reg_en),  32'h008);
    check("jmp_tgt_bub", 32'(bus.bubble),  32'h0);

    // JNZ at 0x20, zero flag set: not taken, skips target word
    fill(8'h00);
    pm[8'h20] = 8'hF0;
    pm[8'h21] = 8'h05;
    pm[8'h22] = 8'h35;
    pm[8'h05] = 8'h6A;
    r_eq_0 = 1'b1;
    do_reset();
    wait_addr(8'h20);
    step();
    check("jnz0_en",     32'(bus.reg_en),  32'h000);
    step();
    check("jnz0_addr",   32'(bus.pm_addr), 32'h22);
    check("jnz0_bubble", 32'(bus.bubble),  32'h1);
    check("jnz0_b_en",   32'(bus.reg_en),  32'h000);
    step();
    check("jnz0_ir",     32'(bus.ir),      32'h35);
    check("jnz0_bub2",   32'(bus.bubble),  32'h0);

    // JNZ with zero flag clear: taken to 0x05
    r_eq_0 = 1'b0;
    do_reset();
    wait_addr(8'h20);
    step();
    check("jnz1_ir",     32'(bus.ir),      32'hF0);
    step();
    check("jnz1_addr",   32'(bus.pm_addr), 32'h05);
    check("jnz1_bubble", 32'(bus.bubble),  32'h1);
    check("jnz1_b_en",   32'(bus.reg_en),  32'h000);
    step();
    check("jnz1_ir2",    32'(bus.ir),      32'h6A);
    check("jnz1_en2",    32'(bus.reg_en),  32'h040);

    // Reset asserted in a jump cycle wins
    fill(8'h00);
    pm[8'h10] = 8'hE0;
    pm[8'h11] = 8'h40;
    do_reset();
    wait_addr(8'h10);
    step();
    sync_reset = 1'b1;
    step();
    check("rstj_addr",   32'(bus.pm_addr), 32'h00);
    check("rstj_bubble", 32'(bus.bubble),  32'h1);
    check("rstj_en",     32'(bus.reg_en),  32'h000);
    sync_reset = 1'b0;

    // Jump opcode sitting in a bubble slot does not redirect
    fill(8'h00);
    pm[8'h30] = 8'hE0;
    pm[8'h31] = 8'hE0;
    pm[8'hE0] = 8'h35;
    pm[8'hE1] = 8'h88;
    do_reset();
    wait_addr(8'h30);
    step();
    step();
    check("bj_addr",     32'(bus.pm_addr), 32'hE0);
    check("bj_bubble",   32'(bus.bubble),  32'h1);
    step();
    check("bj_addr2",    32'(bus.pm_addr), 32'hE1);
    check("bj_ir",       32'(bus.ir),      32'h35);
    check("bj_bubble2",  32'(bus.bubble),  32'h0);

    // pc wraps from FF to 00
    fill(8'h00);
    pm[8'hFF] = 8'h35;
    do_reset();
    wait_addr(8'hFF);
    step();
    check("wrap_addr",   32'(bus.pm_addr), 32'h00);
    check("wrap_ir",     32'(bus.ir),      32'h35);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
